// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy datapath: one-hot flight states and the
// default playfield / bird geometry in pixels and fixed-point fractional bits.
package flappy_pkg;

   typedef enum logic [2:0] {
      ST_INITIAL = 3'b001,
      ST_FLIGHT  = 3'b010,
      ST_STOP    = 3'b100
   } state_t;

   localparam int FRAC_W_DEF   = 2;
   localparam int SCREEN_H_DEF = 480;
   localparam int BIRD_W_DEF   = 20;
   localparam int BIRD_H_DEF   = 20;
   localparam int START_X_DEF  = 300;
   localparam int START_Y_DEF  = 220;
   localparam int COOLDOWN_DEF = 4;

endpackage

// File: rtl/bird_press_latch.sv
// Jump-request capture: rising-edge detect on the button, a pending flag held
// until the next frame tick, and (with JUMP_COOLDOWN_EN) a post-jump lockout.
module bird_press_latch
   import flappy_pkg::*;
`ifdef JUMP_COOLDOWN_EN
#(
   parameter int COOLDOWN = COOLDOWN_DEF
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic in_flight,
   input  logic stop_req,
   input  logic tick_en,
   output logic jump
);

   logic btn_q;
   logic pending_q, pending_d;
   logic edge_seen;
   logic accept;

   // btn_q tracks the level in every state so a button held across Start
   // does not count as a fresh press.
   assign edge_seen = btn && !btn_q;

`ifdef JUMP_COOLDOWN_EN
   localparam int CD_W = $clog2(COOLDOWN + 1);

   logic [CD_W-1:0] cd_q, cd_d;

   assign accept = edge_seen && in_flight && (cd_q == '0);

   always_comb begin
      cd_d = cd_q;
      if (!in_flight) begin
         cd_d = '0;
      end else if (jump) begin
         cd_d = CD_W'(COOLDOWN);
      end else if (tick_en && (cd_q != '0)) begin
         cd_d = cd_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cd_q <= '0;
      end else begin
         cd_q <= cd_d;
      end
   end
`else
   assign accept = edge_seen && in_flight;
`endif

   // An edge arriving together with the tick is consumed by that same tick.
   assign jump = tick_en && (pending_q || accept);

   always_comb begin
      pending_d = pending_q || accept;
      if (!in_flight || stop_req || tick_en) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         btn_q     <= btn;
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/bird_physics_fx.sv
// Fixed-point vertical flight physics with Initial/Flight/Stop handshake.
// Optional macro JUMP_COOLDOWN_EN enables a post-jump lockout of COOLDOWN ticks.
module bird_physics_fx
   import flappy_pkg::*;
#(
   parameter int POS_W    = 10,
   parameter int FRAC_W   = FRAC_W_DEF,
   parameter int VEL_W    = 8,
   parameter int GRAVITY  = 1,
   parameter int JUMP_VEL = 24,
   parameter int TERM_VEL = 32,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int BIRD_W   = BIRD_W_DEF,
   parameter int BIRD_H   = BIRD_H_DEF,
   parameter int START_X  = START_X_DEF,
   parameter int START_Y  = START_Y_DEF
`ifdef JUMP_COOLDOWN_EN
   ,
   parameter int COOLDOWN = COOLDOWN_DEF
`endif
)(
   input  logic                    Clk,
   input  logic                    reset,
   input  logic                    Start,
   input  logic                    Stop,
   input  logic                    Ack,
   input  logic                    BtnPress,
   input  logic                    Tick,
   output logic [POS_W-1:0]        Bird_X_L,
   output logic [POS_W-1:0]        Bird_X_R,
   output logic [POS_W-1:0]        Bird_Y_T,
   output logic [POS_W-1:0]        Bird_Y_B,
   output logic signed [VEL_W-1:0] Velocity,
   output logic                    HitCeil,
   output logic                    HitFloor,
   output logic                    q_Initial,
   output logic                    q_Flight,
   output logic                    q_Stop
);

   localparam int Y_W = POS_W + FRAC_W + 1;

   localparam logic signed [Y_W-1:0] Y_START = Y_W'(START_Y << FRAC_W);
   localparam logic signed [Y_W-1:0] Y_FLOOR = Y_W'((SCREEN_H - BIRD_H) << FRAC_W);
   localparam logic signed [Y_W-1:0] V_JUMP  = Y_W'(-JUMP_VEL);
   localparam logic signed [Y_W-1:0] V_TERM  = Y_W'(TERM_VEL);
   localparam logic signed [Y_W-1:0] V_GRAV  = Y_W'(GRAVITY);

   localparam logic [POS_W-1:0] X_L_C     = POS_W'(START_X);
   localparam logic [POS_W-1:0] X_R_C     = POS_W'(START_X + BIRD_W);
   localparam logic [POS_W-1:0] Y_T_START = POS_W'(START_Y);
   localparam logic [POS_W-1:0] Y_B_START = POS_W'(START_Y + BIRD_H);

   state_t                  state_q, state_d;
   logic signed [Y_W-1:0]   y_q, y_d;
   logic signed [VEL_W-1:0] vel_q, vel_d;
   logic                    hit_ceil_q, hit_ceil_d;
   logic                    hit_floor_q, hit_floor_d;
   logic [POS_W-1:0]        y_t_q, y_t_d;
   logic [POS_W-1:0]        y_b_q, y_b_d;

   logic                    in_flight;
   logic                    tick_en;
   logic                    jump;
   logic signed [Y_W-1:0]   v_ext, v_inc, v_fall, v_new, y_new;

   assign in_flight = (state_q == ST_FLIGHT);
   assign tick_en   = in_flight && Tick && !Stop;

   bird_press_latch
`ifdef JUMP_COOLDOWN_EN
      #(.COOLDOWN(COOLDOWN))
`endif
   u_press (
      .clk       (Clk),
      .rst       (reset),
      .btn       (BtnPress),
      .in_flight (in_flight),
      .stop_req  (Stop),
      .tick_en   (tick_en),
      .jump      (jump)
   );

   // Work at position width so gravity and the jump impulse never wrap.
   always_comb begin
      v_ext  = {{(Y_W - VEL_W){vel_q[VEL_W-1]}}, vel_q};
      v_inc  = v_ext + V_GRAV;
      v_fall = (v_inc > V_TERM) ? V_TERM : v_inc;
      v_new  = jump ? V_JUMP : v_fall;
      y_new  = y_q + v_new;
   end

   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      vel_d       = vel_q;
      hit_ceil_d  = 1'b0;
      hit_floor_d = 1'b0;
      case (state_q)
         ST_INITIAL: begin
            y_d   = Y_START;
            vel_d = '0;
            if (Start) begin
               state_d = ST_FLIGHT;
            end
         end
         ST_FLIGHT: begin
            if (Stop) begin
               state_d = ST_STOP;
            end else if (tick_en) begin
               if (y_new[Y_W-1]) begin
                  y_d        = '0;
                  vel_d      = '0;
                  hit_ceil_d = 1'b1;
               end else if (y_new > Y_FLOOR) begin
                  y_d         = Y_FLOOR;
                  vel_d       = '0;
                  hit_floor_d = 1'b1;
               end else begin
                  y_d   = y_new;
                  vel_d = v_new[VEL_W-1:0];
               end
            end
         end
         ST_STOP: begin
            // Reload on the way out so Initial shows the start box immediately.
            if (Ack) begin
               state_d = ST_INITIAL;
               y_d     = Y_START;
               vel_d   = '0;
            end
         end
         default: begin
            state_d = ST_INITIAL;
            y_d     = Y_START;
            vel_d   = '0;
         end
      endcase
      y_t_d = y_d[FRAC_W +: POS_W];
      y_b_d = y_t_d + POS_W'(BIRD_H);
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_INITIAL;
         y_q         <= Y_START;
         vel_q       <= '0;
         hit_ceil_q  <= 1'b0;
         hit_floor_q <= 1'b0;
         y_t_q       <= Y_T_START;
         y_b_q       <= Y_B_START;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         vel_q       <= vel_d;
         hit_ceil_q  <= hit_ceil_d;
         hit_floor_q <= hit_floor_d;
         y_t_q       <= y_t_d;
         y_b_q       <= y_b_d;
      end
   end

   assign Bird_X_L  = X_L_C;
   assign Bird_X_R  = X_R_C;
   assign Bird_Y_T  = y_t_q;
   assign Bird_Y_B  = y_b_q;
   assign Velocity  = vel_q;
   assign HitCeil   = hit_ceil_q;
   assign HitFloor  = hit_floor_q;
   assign q_Initial = state_q[0];
   assign q_Flight  = state_q[1];
   assign q_Stop    = state_q[2];

endmodule

// File: tb/tb_bird_physics_fx.sv
// Directed bench for bird_physics_fx: vector table for the opening flight,
// hand sequences for floor/ceiling clamps, stop/ack, cooldown and reset.
module tb_bird_physics_fx;

   logic              Clk = 1'b0;
   logic              reset = 1'b1;
   logic              Start = 1'b0;
   logic              Stop = 1'b0;
   logic              Ack = 1'b0;
   logic              BtnPress = 1'b0;
   logic              Tick = 1'b0;
   logic [9:0]        Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
   logic signed [7:0] Velocity;
   logic              HitCeil, HitFloor;
   logic              q_Initial, q_Flight, q_Stop;

   int errors = 0;
   int checks = 0;

   bird_physics_fx dut (
      .Clk       (Clk),
      .reset     (reset),
      .Start     (Start),
      .Stop      (Stop),
      .Ack       (Ack),
      .BtnPress  (BtnPress),
      .Tick      (Tick),
      .Bird_X_L  (Bird_X_L),
      .Bird_X_R  (Bird_X_R),
      .Bird_Y_T  (Bird_Y_T),
      .Bird_Y_B  (Bird_Y_B),
      .Velocity  (Velocity),
      .HitCeil   (HitCeil),
      .HitFloor  (HitFloor),
      .q_Initial (q_Initial),
      .q_Flight  (q_Flight),
      .q_Stop    (q_Stop)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       tick;
      logic       btn;
      logic       start;
      logic       stop;
      logic [2:0] st;
      int         yt;
      int         vel;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic t, input logic b, input logic s, input logic p, input logic a);
      Tick = t; BtnPress = b; Start = s; Stop = p; Ack = a;
      @(posedge Clk); #1;
      Tick = 1'b0; Start = 1'b0; Stop = 1'b0; Ack = 1'b0;
   endtask

   function automatic int st_bits();
      return int'({q_Stop, q_Flight, q_Initial});
   endfunction

   // Press coincident with a tick, then release for one cycle.
   task automatic jump_tick(input string name, input int exp_yt, input int exp_vel, input int exp_hc);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check({name, "_yt"}, int'(Bird_Y_T), exp_yt);
      check({name, "_vel"}, int'(Velocity), exp_vel);
      check({name, "_hitceil"}, int'(HitCeil), exp_hc);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic quiet_jump();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int   max_v;
      logic landed;

      vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 220,   0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 220,   1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 220,   2};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 221,   3};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 222,   4};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 222,   4};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 216, -24};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 210, -23};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 210, -23};

      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      check("rst_state", st_bits(), 1);
      check("rst_xl", int'(Bird_X_L), 300);
      check("rst_xr", int'(Bird_X_R), 320);
      check("rst_yt", int'(Bird_Y_T), 220);
      check("rst_yb", int'(Bird_Y_B), 240);
      check("rst_vel", int'(Velocity), 0);
      check("rst_hits", int'({HitCeil, HitFloor}), 0);
      reset = 1'b0;
      @(posedge Clk); #1;

      // Opening flight from the table
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].tick, vecs[i].btn, vecs[i].start, vecs[i].stop, 1'b0);
         $display("vec %0d: tick=%0b btn=%0b start=%0b -> st=%03b yt=%0d yb=%0d vel=%0d",
                  i, vecs[i].tick, vecs[i].btn, vecs[i].start, st_bits(),
                  Bird_Y_T, Bird_Y_B, Velocity);
         check($sformatf("vec%0d_state", i), st_bits(), int'(vecs[i].st));
         check($sformatf("vec%0d_yt", i), int'(Bird_Y_T), vecs[i].yt);
         check($sformatf("vec%0d_yb", i), int'(Bird_Y_B), vecs[i].yt + 20);
         check($sformatf("vec%0d_vel", i), int'(Velocity), vecs[i].vel);
         check($sformatf("vec%0d_hits", i), int'({HitCeil, HitFloor}), 0);
      end

      // Free fall to the floor
      max_v = -128;
      landed = 1'b0;
      for (int i = 0; i < 300 && !landed; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (int'(Velocity) > max_v) max_v = int'(Velocity);
         if (HitFloor) landed = 1'b1;
      end
      $display("floor: landed=%0b yt=%0d yb=%0d vel=%0d max_v=%0d", landed, Bird_Y_T, Bird_Y_B, Velocity, max_v);
      check("floor_reached", int'(landed), 1);
      check("term_vel", max_v, 32);
      check("floor_yt", int'(Bird_Y_T), 460);
      check("floor_yb", int'(Bird_Y_B), 480);
      check("floor_vel", int'(Velocity), 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("floor_pulse_len", int'(HitFloor), 0);

      // Jump up from 1840 fx to 40 fx, then hit the ceiling
      for (int i = 0; i < 75; i++) quiet_jump();
      $display("climb: yt=%0d vel=%0d", Bird_Y_T, Velocity);
      check("climb_yt", int'(Bird_Y_T), 10);
      check("climb_vel", int'(Velocity), -24);
      jump_tick("ceil_a", 4, -24, 0);
      jump_tick("ceil_b", 0, 0, 1);
      check("ceil_pulse_len", int'(HitCeil), 0);

      // Stop together with Tick freezes; Tick/press ignored; Ack returns
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      $display("stop: st=%03b yt=%0d vel=%0d", st_bits(), Bird_Y_T, Velocity);
      check("stop_state", st_bits(), 4);
      check("stop_vel", int'(Velocity), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("stop_frozen_yt", int'(Bird_Y_T), 0);
      check("stop_frozen_vel", int'(Velocity), 0);
      check("stop_frozen_state", st_bits(), 4);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      $display("ack: st=%03b yt=%0d vel=%0d", st_bits(), Bird_Y_T, Velocity);
      check("ack_state", st_bits(), 1);
      check("ack_yt", int'(Bird_Y_T), 220);
      check("ack_vel", int'(Velocity), 0);

      // Second flight: 33 ticks to 1440 fx, 60 jumps land exactly on 0 (no hit)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("fall33: yt=%0d vel=%0d", Bird_Y_T, Velocity);
      check("fall33_yt", int'(Bird_Y_T), 360);
      check("fall33_vel", int'(Velocity), 32);
      for (int i = 0; i < 59; i++) quiet_jump();
      check("pre_edge_yt", int'(Bird_Y_T), 6);
      jump_tick("ceil_exact", 0, -24, 0);
      jump_tick("ceil_over", 0, 0, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("ack2_state", st_bits(), 1);

`ifdef JUMP_COOLDOWN_EN
      // Cooldown: second press two ticks after a jump is dropped, fifth tick accepts
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      jump_tick("cd_first", 214, -24, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("cd_t1_vel", int'(Velocity), -23);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("cd_t2_ignored_vel", int'(Velocity), -22);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("cd_t4_vel", int'(Velocity), -20);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("cooldown: vel after tick5=%0d", Velocity);
      check("cd_t5_accept_vel", int'(Velocity), -24);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

      // Reset mid-flight takes effect without waiting for a clock edge
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("pre_rst_vel", int'(Velocity), 2);
      #2 reset = 1'b1;
      #1;
      $display("async reset: st=%03b yt=%0d vel=%0d", st_bits(), Bird_Y_T, Velocity);
      check("arst_state", st_bits(), 1);
      check("arst_yt", int'(Bird_Y_T), 220);
      check("arst_vel", int'(Velocity), 0);
      @(posedge Clk); #1;
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
